// File: rtl/codec_intf_pkg.sv
// Shared constants and types for the CS4272 serial audio interface.
// Frame timing is fixed at 1024 system clocks: 2 halves x 32 slots x 16 clocks.
package codec_intf_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FRAME_CNT_W = 10;
  localparam int SLOT_W      = 5;

  localparam logic [3:0] RX_SAMPLE_PH = 4'b0111;
  localparam logic [3:0] TX_SHIFT_PH  = 4'b1111;

  localparam logic [FRAME_CNT_W-1:0] LEFT_LOAD_CNT  = 10'd1023;
  localparam logic [FRAME_CNT_W-1:0] RIGHT_LOAD_CNT = 10'd511;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_CODEC_RST,
    ST_WARMUP,
    ST_RUN
  } link_state_e;

  // Slots beyond the sample width are padding within the 32-bit slot.
  function automatic logic is_data_slot(input logic [SLOT_W-1:0] slot, input int data_w);
    return 32'(slot) < data_w;
  endfunction

endpackage

// File: rtl/audio_shift_reg.sv
// MSB-first shift register: parallel load wins over shift; serial out is the MSB.
// Latency: one clk from load/shift to outputs; no backpressure.
module audio_shift_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_dat,
  input  logic         i_shift,
  input  logic         i_ser,
  output logic         o_ser,
  output logic [W-1:0] o_par
);

  logic [W-1:0] r_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_load_dat;
    end else if (i_shift) begin
      r_sh <= {r_sh[W-2:0], i_ser};
    end
  end

  assign o_ser = r_sh[W-1];
  assign o_par = r_sh;

endmodule

// File: rtl/codec_intf.sv
// CS4272 left-justified serial interface: clock generation, ADC deserialise, DAC serialise.
// Latency: samples captured at vld go out in the next frame; no backpressure (fixed frame rate).
module codec_intf
  import codec_intf_pkg::*;
#(
  parameter int DATA_W         = SAMPLE_W,
  parameter int STARTUP_FRAMES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] lft_in,
  input  logic signed [DATA_W-1:0] rht_in,
  output logic signed [DATA_W-1:0] lft_out,
  output logic signed [DATA_W-1:0] rht_out,
  output logic                     vld,
  output logic                     MCLK,
  output logic                     SCLK,
  output logic                     LRCLK,
  output logic                     SDin,
  input  logic                     SDout,
  output logic                     RSTn
);

  localparam int SU_W = (STARTUP_FRAMES < 2) ? 1 : $clog2(STARTUP_FRAMES);

  logic [FRAME_CNT_W-1:0] r_cnt;
  logic                   r_mclk, r_sclk, r_lrclk, r_rstn, r_vld;
  logic [DATA_W-1:0]      r_lft_out, r_rht_out, r_hold_l, r_hold_r;
  link_state_e            r_state;
  logic [SU_W-1:0]        r_su_cnt;

  logic [FRAME_CNT_W-1:0] w_cnt_nxt;
  logic                   w_wrap;
  link_state_e            w_state_nxt;
  logic [SU_W-1:0]        w_su_cnt_nxt;
  logic                   w_vld_nxt;
  logic                   w_rx_sample, w_rx_l_shift, w_rx_r_shift;
  logic                   w_tx_left_ld, w_tx_right_ld, w_tx_load, w_tx_shift;
  logic [DATA_W-1:0]      w_tx_load_dat;
  logic [DATA_W-1:0]      w_rx_l_par, w_rx_r_par;
  logic                   w_tx_ser;
  logic                   w_rx_l_ser_unused, w_rx_r_ser_unused;
  logic [DATA_W-1:0]      w_tx_par_unused;

  assign w_cnt_nxt = r_cnt + FRAME_CNT_W'(1);
  assign w_wrap    = (r_cnt == LEFT_LOAD_CNT);

  // Clock outputs are registered from the next count so they match the current cnt decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_mclk  <= 1'b0;
      r_sclk  <= 1'b0;
      r_lrclk <= 1'b1;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_mclk  <= w_cnt_nxt[1];
      r_sclk  <= w_cnt_nxt[3];
      r_lrclk <= ~w_cnt_nxt[9];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_CODEC_RST;
      r_su_cnt <= '0;
      r_rstn   <= 1'b0;
      r_vld    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_su_cnt <= w_su_cnt_nxt;
      r_rstn   <= (w_state_nxt != ST_CODEC_RST);
      r_vld    <= w_vld_nxt;
    end
  end

  // Codec held in reset for one frame, then warmed up for STARTUP_FRAMES frames.
  always_comb begin
    w_state_nxt  = r_state;
    w_su_cnt_nxt = r_su_cnt;
    if (w_wrap) begin
      case (r_state)
        ST_CODEC_RST: begin
          w_su_cnt_nxt = '0;
          w_state_nxt  = (STARTUP_FRAMES == 0) ? ST_RUN : ST_WARMUP;
        end
        ST_WARMUP: begin
          if (r_su_cnt == SU_W'(STARTUP_FRAMES - 1)) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_su_cnt_nxt = r_su_cnt + SU_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_vld_nxt = (w_cnt_nxt == LEFT_LOAD_CNT) && (r_state == ST_RUN);

  assign w_rx_sample  = (r_cnt[3:0] == RX_SAMPLE_PH) && is_data_slot(r_cnt[8:4], DATA_W);
  assign w_rx_l_shift = w_rx_sample && !r_cnt[9];
  assign w_rx_r_shift = w_rx_sample &&  r_cnt[9];

  audio_shift_reg #(.W(DATA_W)) u_rx_l (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (1'b0),
    .i_load_dat ('0),
    .i_shift    (w_rx_l_shift),
    .i_ser      (SDout),
    .o_ser      (w_rx_l_ser_unused),
    .o_par      (w_rx_l_par)
  );

  audio_shift_reg #(.W(DATA_W)) u_rx_r (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (1'b0),
    .i_load_dat ('0),
    .i_shift    (w_rx_r_shift),
    .i_ser      (SDout),
    .o_ser      (w_rx_r_ser_unused),
    .o_par      (w_rx_r_par)
  );

  // Left word bypasses the holding register on the vld cycle so it goes out in the very next frame.
  assign w_tx_left_ld  = (r_cnt == LEFT_LOAD_CNT);
  assign w_tx_right_ld = (r_cnt == RIGHT_LOAD_CNT);
  assign w_tx_load     = w_tx_left_ld || w_tx_right_ld;
  assign w_tx_shift    = (r_cnt[3:0] == TX_SHIFT_PH);
  assign w_tx_load_dat = w_tx_right_ld ? r_hold_r : (r_vld ? lft_in : r_hold_l);

  // Zeros shifted in behind the sample provide the padding slots.
  audio_shift_reg #(.W(DATA_W)) u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tx_load),
    .i_load_dat (w_tx_load_dat),
    .i_shift    (w_tx_shift),
    .i_ser      (1'b0),
    .o_ser      (w_tx_ser),
    .o_par      (w_tx_par_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lft_out <= '0;
      r_rht_out <= '0;
      r_hold_l  <= '0;
      r_hold_r  <= '0;
    end else begin
      if (w_vld_nxt) begin
        r_lft_out <= w_rx_l_par;
        r_rht_out <= w_rx_r_par;
      end
      if (r_vld) begin
        r_hold_l <= lft_in;
        r_hold_r <= rht_in;
      end
    end
  end

  assign lft_out = r_lft_out;
  assign rht_out = r_rht_out;
  assign vld     = r_vld;
  assign MCLK    = r_mclk;
  assign SCLK    = r_sclk;
  assign LRCLK   = r_lrclk;
  assign SDin    = w_tx_ser;
  assign RSTn    = r_rstn;

endmodule
